// File: rtl/baud_tx_arbiter.sv
// baud_tx_arbiter: round-robin two-requester 8N1 UART transmitter.
// Define PARITY_EN to insert an even-parity bit between data and stop.
module baud_tx_arbiter #(
  parameter int SYS_CLK = 100_000_000,
  parameter int BAUD = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       tx,
  output logic       busy
);
  localparam logic [31:0] DIV = 32'(SYS_CLK / BAUD);
`ifdef PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t state, state_n;
  logic [31:0] cnt;
  logic [2:0] idx;
  logic [7:0] shreg;
  logic ptr, tick, pick1;
  assign tick = cnt == DIV - 32'd1;
  always_comb begin
    pick1 = req1 && (!req0 || ptr);
    gnt1 = rst_n && state == IDLE && pick1;
    gnt0 = rst_n && state == IDLE && req0 && !pick1;
    busy = state != IDLE || gnt0 || gnt1;
`ifdef PARITY_EN
    tx = state == START ? 1'b0 : state == DATA ? shreg[0] : state == PARITY ? ^shreg : 1'b1;
`else
    tx = state == START ? 1'b0 : state == DATA ? shreg[0] : 1'b1;
`endif
    state_n = state;
    case (state)
      IDLE:   state_n = (req0 || req1) ? START : IDLE;
      START:  state_n = tick ? DATA : START;
`ifdef PARITY_EN
      DATA:   state_n = (tick && idx == 3'd7) ? PARITY : DATA;
      PARITY: state_n = tick ? STOP : PARITY;
`else
      DATA:   state_n = (tick && idx == 3'd7) ? STOP : DATA;
`endif
      STOP:   state_n = tick ? IDLE : STOP;
      default: state_n = IDLE;
    endcase
  end
  // the shift register rotates, so after 8 bits it again holds the byte for parity
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      shreg <= '0;
      ptr <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= (state == IDLE || tick) ? '0 : cnt + 32'd1;
      if (gnt0 || gnt1) begin
        shreg <= gnt1 ? data1 : data0;
        ptr <= gnt0;
      end else if (state == DATA && tick) begin
        shreg <= {shreg[0], shreg[7:1]};
        idx <= idx + 3'd1;
      end
    end
  end
endmodule

// File: tb/tb_baud_tx_arbiter.sv
// tb_baud_tx_arbiter: directed and random frames checked against a slot-based line model.
module tb_baud_tx_arbiter;
  localparam int DIV = 10;
`ifdef PARITY_EN
  localparam int NSLOT = 11;
`else
  localparam int NSLOT = 10;
`endif
  logic clk = 0, rst_n = 1, req0 = 0, req1 = 0;
  logic [7:0] data0 = 0, data1 = 0;
  logic gnt0, gnt1, tx, busy;
  int passed = 0, failed = 0, total = 0;
  bit mptr = 0;

  baud_tx_arbiter #(.SYS_CLK(1000), .BAUD(100)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .data0(data0), .data1(data1),
    .gnt0(gnt0), .gnt1(gnt1), .tx(tx), .busy(busy));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic logic exp_bit(input logic [7:0] d, input int k);
    int slot = k / DIV;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return d[slot-1];
`ifdef PARITY_EN
    if (slot == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  task automatic idle_check();
    check("idle_busy", 32'(busy), 0);
    check("idle_tx", 32'(tx), 1);
    check("idle_gnt", 32'(gnt0 | gnt1), 0);
  endtask

  task automatic do_reset();
    rst_n = 0;
    #1;
    check("rst_tx", 32'(tx), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_gnt", 32'({gnt0, gnt1}), 0);
    mptr = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    #1;
  endtask

  // drop: 0 keep requests, 1 release granted requester, 2 release both
  task automatic frame(input int maxw, input bit imm, input int drop, input bit chg, input int abort_k);
    int n = 0;
    int who;
    logic [7:0] d;
    #1;
    while (!(gnt0 || gnt1) && n < maxw) begin
      step();
      n++;
    end
    who = (req0 && req1) ? int'(mptr) : int'(req1);
    check("grant_seen", 32'(gnt0 | gnt1), 1);
    if (imm) check("grant_gap", 32'(n), 0);
    check("gnt0", 32'(gnt0), 32'(who == 0));
    check("gnt1", 32'(gnt1), 32'(who == 1));
    check("busy_grant", 32'(busy), 1);
    check("tx_grant", 32'(tx), 1);
    d = who == 1 ? data1 : data0;
    mptr = who == 0;
    for (int k = 0; k < NSLOT * DIV; k++) begin
      @(negedge clk);
      if (k == 0 && drop == 2) begin req0 = 0; req1 = 0; end
      if (k == 0 && drop == 1) begin if (who == 1) req1 = 0; else req0 = 0; end
      if (chg && k == 1) begin data0 = ~data0; data1 = 8'($urandom); end
      #1;
      check("tx_bit", 32'(tx), 32'(exp_bit(d, k)));
      check("busy_frame", 32'(busy), 1);
      check("gnt_frame", 32'(gnt0 | gnt1), 0);
      if (k == abort_k) return;
    end
  endtask

  initial begin
    #2;
    do_reset();
    req1 = 1; data1 = 8'h5C;
    frame(3, 1, 1, 0, -1);
    step(); idle_check();
    req0 = 1; data0 = 8'hA5;
    frame(3, 1, 1, 0, -1);
    step(); idle_check();
    req0 = 1; data0 = 8'h07;
    frame(3, 1, 1, 0, -1);
    step(); idle_check();
    req0 = 1; data0 = 8'h03;
    frame(3, 1, 1, 0, -1);
    step(); idle_check();
    req0 = 1; data0 = 8'h0F;
    frame(3, 1, 1, 1, -1);
    step(); idle_check();
    do_reset();
    req0 = 1; req1 = 1; data0 = 8'h11; data1 = 8'h22;
    frame(3, 1, 0, 0, -1);
    step();
    frame(3, 1, 0, 0, -1);
    step();
    frame(3, 1, 2, 0, -1);
    step(); idle_check();
    for (int i = 0; i < 8; i++) begin
      req0 = 1'($urandom_range(0, 1));
      req1 = !req0 ? 1'b1 : 1'($urandom_range(0, 1));
      data0 = 8'($urandom); data1 = 8'($urandom);
      frame(3, 1, 1, 1, -1);
      step();
      if (req0 || req1) begin
        frame(3, 1, 1, 1, -1);
        step();
      end
      idle_check();
    end
    req0 = 1; req1 = 0; data0 = 8'($urandom);
    frame(3, 1, 1, 0, 4 * DIV + 3);
    req0 = 1; req1 = 1; data0 = 8'($urandom); data1 = 8'($urandom);
    do_reset();
    frame(3, 1, 2, 0, -1);
    step(); idle_check();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/baud_tx_arbiter.md
BAUD_TX_ARBITER -- requirements
Module: baud_tx_arbiter

Interface
REQ-001 SHALL have parameter SYS_CLK, default 100_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, serial bit rate in Bd.
REQ-003 SHALL have port clk, input, 1, system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports req0 / req1, input, 1 each, requester holds high while its byte is pending.
REQ-006 SHALL have ports data0 / data1, input, 8 each, byte of the matching requester, valid while its req is high.
REQ-007 SHALL have ports gnt0 / gnt1, output, 1 each, one-cycle pulse: byte accepted and latched.
REQ-008 SHALL have port tx, output, 1, serial line, idle high.
REQ-009 SHALL have port busy, output, 1, high from the grant cycle through the last stop-bit cycle.

Function
REQ-010 SHALL derive DIV = SYS_CLK/BAUD (integer division); a 32-bit tick counter counts 0..DIV-1 and asserts an internal bit tick when the count equals DIV-1, then wraps to 0.
REQ-011 SHALL implement the states IDLE, START, DATA, PARITY, STOP.
REQ-012 IDLE: tx=1, busy=0, tick counter held at 0; if req0 or req1 is high, grant exactly one requester, latch its data into the shift register, pulse its gnt for one cycle, and enter START with busy=1.
REQ-013 Arbitration SHALL be round-robin: a 1-bit pointer selects the preferred requester; the pointer resets to requester 0 and after every grant points to the other requester.
REQ-014 With a single request pending, that requester SHALL be granted regardless of the pointer.
REQ-015 START SHALL drive tx=0 for exactly DIV cycles, then enter DATA.
REQ-016 DATA SHALL shift out the 8 bits LSB first, each for exactly DIV cycles, using a 3-bit bit index; after bit 7 it enters PARITY (REQ-024) or STOP.
REQ-017 STOP SHALL drive tx=1 for exactly DIV cycles, then return to IDLE.
REQ-018 busy SHALL fall in the IDLE cycle following STOP; a pending request is granted in that same cycle, giving a one-clock inter-frame gap.
REQ-019 req or data changes after the grant cycle SHALL NOT affect the frame in progress; requests arriving during a frame wait until IDLE.
REQ-020 gnt0 and gnt1 SHALL never be high in the same cycle, and never outside IDLE.
REQ-021 Frame length from START entry to IDLE return SHALL be 10*DIV cycles, or 11*DIV with parity.

Reset
REQ-022 While rst_n=0: state=IDLE, tx=1, busy=0, gnt0=gnt1=0, tick counter=0, bit index=0, shift register=0, pointer=0, all asynchronously.
REQ-023 Reset asserted mid-frame SHALL abort the frame immediately with no completion; after release the block starts from IDLE with pointer=0.

Configuration
REQ-024 With macro PARITY_EN defined, the PARITY state SHALL drive the even-parity bit (XOR of the 8 latched data bits) for DIV cycles between DATA and STOP; without PARITY_EN, the PARITY state and its logic SHALL be absent and DATA proceeds directly to STOP.

Verification (bench uses SYS_CLK=1000, BAUD=100, so DIV=10)
REQ-025 Single request: req0=1, data0=0xA5 -> gnt0 pulses 1 cycle, tx = 0 for 10 cycles, then 1,0,1,0,0,1,0,1 at 10 cycles each, then 1 for 10 cycles; busy high for 101 cycles; without PARITY_EN, 100 cycles of frame.
REQ-026 Simultaneous requests after reset: req0=req1=1, data0=0x11, data1=0x22 held -> gnt0 first, frame 0x11, one IDLE cycle, gnt1, frame 0x22, then gnt0 again.
REQ-027 Only req1 pending with pointer=0 -> gnt1 in the first IDLE cycle and frame of data1.
REQ-028 Mid-frame data change: grant with data0=0x0F, then data0=0xF0 in cycle 2 -> transmitted bits match 0x0F.
REQ-029 Reset in DATA bit 3: rst_n=0 for 3 cycles -> tx=1, busy=0, gnt=0 immediately; with req1 pending after release, the next grant is gnt0 if req0 is also pending (pointer=0).
REQ-030 PARITY_EN defined, data0=0x07 -> parity bit 1 for 10 cycles after bit 7; 0x03 -> parity bit 0; frame length 110 cycles.
